// File: rtl/alu_mc_if.sv
// Request/response bundle for the multi-cycle ALU: operation request in, result and zero flag out.
interface alu_mc_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic [3:0]  ALUControl;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        zero;

   // Requester side: issues operations and consumes results
   modport master (
      output in_valid, a, b, ALUControl, out_ready,
      input  in_ready, out_valid, result, zero
   );

   // ALU side
   modport slave (
      input  in_valid, a, b, ALUControl, out_ready,
      output in_ready, out_valid, result, zero
   );
endinterface

// File: rtl/alu_mc.sv
// 64-bit ALU: logic/add/sub/pass-b complete in one cycle; MUL runs a 64-step shift-add
// multiplier. One operation in flight; the result is held until the consumer takes it.
module alu_mc (
   input logic       clk,
   input logic       reset,
   alu_mc_if.slave   bus
);
   localparam int unsigned DW = 64;
   localparam int unsigned CW = 6;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_PASB = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;

   localparam logic [DW-1:0] DEFAULT_RESULT = DW'(20'hfffff);
   localparam logic [CW-1:0] LAST_ITER      = CW'(DW - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [DW-1:0]   res_q;
   logic [DW-1:0]   mcand_q;
   logic [DW-1:0]   mplier_q;
   logic [DW-1:0]   acc_q;
   logic [CW-1:0]   cnt_q;
   logic            vld_q;

   logic [DW-1:0]   alu_c;
   logic [DW-1:0]   acc_next_c;

   // Single-cycle datapath, evaluated on the live inputs at the accept edge
   always_comb begin
      alu_c = DEFAULT_RESULT;
      case (bus.ALUControl)
         OP_AND:  alu_c = bus.a & bus.b;
         OP_OR:   alu_c = bus.a | bus.b;
         OP_ADD:  alu_c = bus.a + bus.b;
         OP_SUB:  alu_c = bus.a - bus.b;
         OP_PASB: alu_c = bus.b;
         default: alu_c = DEFAULT_RESULT;
      endcase
   end

   // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set
   always_comb begin
      acc_next_c = acc_q;
      if (mplier_q[0]) begin
         acc_next_c = acc_q + mcand_q;
      end
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         res_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         vld_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  mcand_q  <= bus.a;
                  mplier_q <= bus.b;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  if (bus.ALUControl == OP_MUL) begin
                     state <= MUL;
                  end else begin
                     res_q <= alu_c;
                     vld_q <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            MUL: begin
               acc_q    <= acc_next_c;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == LAST_ITER) begin
                  res_q <= acc_next_c;
                  vld_q <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  vld_q <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               vld_q <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = vld_q;
   assign bus.result    = res_q;
   assign bus.zero      = (res_q == '0);

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: hand-computed vectors, latency, DONE hold, reset abort.
module tb_alu_mc;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   alu_mc_if bus ();

   alu_mc dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one operation, measure latency, check result/zero, optionally complete the handshake.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                         input bit do_hs);
      int lat;
      @(negedge clk);
      check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid   = 1'b1;
      bus.a          = a;
      bus.b          = b;
      bus.ALUControl = op;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a        = 64'h0;
      bus.b        = 64'h0;
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      check({tag, ".result"}, bus.result, exp);
      check({tag, ".zero"}, 64'(bus.zero), 64'(exp == 64'h0));
      if (do_hs) begin
         bus.out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bus.out_ready = 1'b0;
         check({tag, ".hs_in_ready"}, 64'(bus.in_ready), 64'd1);
         check({tag, ".hs_out_valid"}, 64'(bus.out_valid), 64'd0);
      end
   endtask

   initial begin
      logic [63:0] held;
      errors         = 0;
      checks         = 0;
      reset          = 1'b1;
      bus.in_valid   = 1'b0;
      bus.a          = 64'h0;
      bus.b          = 64'h0;
      bus.ALUControl = 4'h0;
      bus.out_ready  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst.in_ready", 64'(bus.in_ready), 64'd1);
      check("rst.out_valid", 64'(bus.out_valid), 64'd0);
      check("rst.result", bus.result, 64'h0);
      check("rst.zero", 64'(bus.zero), 64'd1);

      // Single-cycle operations
      run_op("and",  4'b0000, 64'habcde,    64'hef8965,  64'ha8844,    1, 1'b1);
      run_op("or",   4'b0001, 64'hf0,       64'h0f,      64'hff,       1, 1'b1);
      run_op("add",  4'b0010, 64'h12345678, 64'h75abef,  64'h12aa0267, 1, 1'b1);
      run_op("sub",  4'b0110, 64'h12345678, 64'h75abef,  64'h11beaa89, 1, 1'b1);
      run_op("sub0", 4'b0110, 64'h5,        64'h5,       64'h0,        1, 1'b1);
      run_op("addw", 4'b0010, 64'hffffffffffffffff, 64'h2, 64'h1,     1, 1'b1);
      run_op("pasb", 4'b0111, 64'h9999,     64'h1234,    64'h1234,     1, 1'b1);
      run_op("d1111", 4'b1111, 64'h1,       64'h2,       64'hfffff,    1, 1'b1);
      run_op("d1110", 4'b1110, 64'h1,       64'h2,       64'hfffff,    1, 1'b1);
      run_op("d0011", 4'b0011, 64'h1,       64'h2,       64'hfffff,    1, 1'b1);

      // Multiplies
      run_op("mul1", 4'b1000, 64'h12345, 64'h10, 64'h123450, 65, 1'b1);
      run_op("mul2", 4'b1000, 64'hffffffffffffffff, 64'h2, 64'hfffffffffffffffe, 65, 1'b1);
      run_op("mul3", 4'b1000, 64'h3, 64'h5, 64'hf, 65, 1'b1);
      run_op("mul4", 4'b1000, 64'h8000000000000000, 64'h8000000000000001,
             64'h8000000000000000, 65, 1'b1);

      // DONE hold: consumer stalls 10 cycles while requester pulses in_valid
      run_op("hold", 4'b0010, 64'h100, 64'h23, 64'h123, 1, 1'b0);
      held = bus.result;
      for (int i = 0; i < 10; i++) begin
         bus.in_valid   = i[0];
         bus.a          = 64'(i);
         bus.b          = 64'h7;
         bus.ALUControl = 4'b0001;
         @(posedge clk);
         @(negedge clk);
         check("hold.out_valid", 64'(bus.out_valid), 64'd1);
         check("hold.result", bus.result, held);
         check("hold.in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("hold.hs_in_ready", 64'(bus.in_ready), 64'd1);
      check("hold.hs_result", bus.result, 64'h123);

      // Reset during MUL aborts the operation; consumer ready throughout
      bus.in_valid   = 1'b1;
      bus.a          = 64'h777;
      bus.b          = 64'h3;
      bus.ALUControl = 4'b1000;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (30) @(negedge clk);
      check("abort.in_ready_mul", 64'(bus.in_ready), 64'd0);
      bus.out_ready = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("abort.in_ready", 64'(bus.in_ready), 64'd1);
      check("abort.out_valid", 64'(bus.out_valid), 64'd0);
      check("abort.result", bus.result, 64'h0);
      check("abort.zero", 64'(bus.zero), 64'd1);
      begin
         int seen;
         seen = 0;
         repeat (70) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
         end
         check("abort.no_result", 64'(seen), 64'd0);
      end
      bus.out_ready = 1'b0;
      run_op("post", 4'b0010, 64'h40, 64'h2, 64'h42, 1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
